// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC sequencer with INIT/RUN/HALTED FSM; define FETCH_IREG_EN to register instr
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic [31:0]      instr_in,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             trap_misalign,
    output logic [CNT_W-1:0] fetch_cnt
);
    typedef enum logic [1:0] {INIT, RUN, HALTED} state_t;
    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trap_q, trap_d;
    logic             in_run, mis, adv;
    assign mis = br_taken & (br_target[1:0] != 2'b00);
    // state register
    always_ff @(posedge clk)
        state_q <= rst ? INIT : state_d;
    // next state: INIT lasts one cycle, a misaligned redirect halts until reset
    always_comb
        state_d = state_q == INIT ? RUN : (state_q == RUN && mis) ? HALTED : state_q;
    // FSM outputs: pc may only move in RUN, and never on a misaligned redirect
    always_comb begin
        in_run = state_q == RUN;
        adv    = in_run & ~mis & (br_taken | ~stall);
    end
    // next PC, saturating advance counter and sticky trap
    always_comb begin
        pc_d   = !adv ? pc_q : br_taken ? br_target : pc_q + 32'd4;
        cnt_d  = (adv && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
        trap_d = trap_q | (in_run & mis);
    end
    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            cnt_q  <= '0;
            trap_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            trap_q <= trap_d;
        end
    end
    assign pc            = pc_q;
    assign pc_plus4      = pc_q + 32'd4;
    assign fetch_cnt     = cnt_q;
    assign trap_misalign = trap_q;
`ifdef FETCH_IREG_EN
    logic [31:0] instr_q;
    logic        ivalid_q;
    // instruction register: flush on redirect, hold on stall, capture otherwise
    always_ff @(posedge clk) begin
        if (rst || !in_run || br_taken) begin
            ivalid_q <= 1'b0;
        end else if (!stall) begin
            instr_q  <= instr_in;
            ivalid_q <= 1'b1;
        end
    end
    assign instr       = instr_q;
    assign instr_valid = ivalid_q & in_run;
`else
    assign instr       = instr_in;
    assign instr_valid = in_run;
`endif
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset (word-aligned).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the fetch-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port stall, input, 1, hold the current PC.
REQ-006 SHALL have port br_taken, input, 1, redirect request (branch/jal/jalr resolved this cycle).
REQ-007 SHALL have port br_target, input, 32, the redirect address.
REQ-008 SHALL have port instr_in, input, 32, the word returned combinationally by instruction memory for address pc.
REQ-009 SHALL have port pc, output, 32, the fetch address driven to instruction memory.
REQ-010 SHALL have port pc_plus4, output, 32, pc+4, for the link-register writeback.
REQ-011 SHALL have port instr, output, 32, the instruction to the decoder.
REQ-012 SHALL have port instr_valid, output, 1, instr is a valid fetched word.
REQ-013 SHALL have port trap_misalign, output, 1, sticky flag for a misaligned redirect.
REQ-014 SHALL have port fetch_cnt, output, CNT_W, count of PC advances.

Function
REQ-015 SHALL implement FSM states INIT, RUN and HALTED; INIT→RUN unconditionally after one cycle; RUN→HALTED on a misaligned redirect; HALTED exits only via rst.
REQ-016 SHALL, in RUN, apply next-PC priority: misaligned redirect (br_taken & br_target[1:0]!=0) > br_taken > stall > sequential.
REQ-017 SHALL, in RUN, load br_target on an aligned br_taken even when stall=1.
REQ-018 SHALL, in RUN with stall=1 and br_taken=0, hold pc unchanged.
REQ-019 SHALL, in RUN otherwise, load pc+4, wrapping modulo 2^32 (0xFFFF_FFFC→0x0000_0000).
REQ-020 SHALL, on a misaligned redirect, keep pc unchanged, set trap_misalign=1 next cycle and enter HALTED.
REQ-021 SHALL hold pc in INIT and HALTED.
REQ-022 SHALL drive pc_plus4 = pc+4 combinationally at all times, with the same wrap as REQ-019.
REQ-023 SHALL increment fetch_cnt by 1 on each RUN cycle in which pc changes (sequential or aligned redirect), saturating at all-ones.
REQ-024 SHALL drive instr_valid=0 in INIT and HALTED.
REQ-025 SHALL drive trap_misalign high only from HALTED entry until rst.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, override all other inputs and set pc=RESET_PC, state=INIT, fetch_cnt=0, trap_misalign=0 and instr_valid=0.
REQ-027 SHALL, when rst is asserted mid-operation (including in HALTED), take the same reset action on the next edge, with no partial update.

Configuration
REQ-028 SHALL, with macro FETCH_IREG_EN undefined, drive instr=instr_in combinationally and instr_valid=(state==RUN).
REQ-029 SHALL, with FETCH_IREG_EN defined, register instr from instr_in each non-stalled RUN cycle, so instr_valid rises one cycle after RUN entry.
REQ-030 SHALL, with FETCH_IREG_EN defined and an aligned br_taken, clear instr_valid for exactly the next cycle (flush).
REQ-031 SHALL, with FETCH_IREG_EN defined and stall=1 with no redirect, hold both instr and instr_valid.

Verification
REQ-032 Bench SHALL cover sequential fetch: rst for 1 cycle, then 5 idle cycles -> pc sequence 0,0,4,8,12 (INIT hold, then RUN); fetch_cnt=3; instr_valid=1 from cycle 2.
REQ-033 Bench SHALL cover stall: stall=1 for 2 cycles at pc=8 -> pc stays 8 and fetch_cnt does not change; on release, pc=12 next cycle.
REQ-034 Bench SHALL cover an aligned redirect: br_taken=1, br_target=0x40, stall=1 at pc=16 -> pc=0x40 next cycle, pc_plus4=0x44; with FETCH_IREG_EN, instr_valid=0 for one cycle.
REQ-035 Bench SHALL cover a misaligned redirect: br_taken=1, br_target=0x2A -> pc unchanged, trap_misalign=1, instr_valid=0 and pc frozen for 10 further cycles; then rst -> pc=RESET_PC, trap_misalign=0.
REQ-036 Bench SHALL cover wrap and saturation: redirect to 0xFFFF_FFFC -> next pc=0x0000_0000, pc_plus4 at 0xFFFF_FFFC equals 0; with CNT_W=4 and 20 advances, fetch_cnt=15.
REQ-037 Bench SHALL cover reset mid-run: rst=1 together with br_taken=1 at pc=0x20 -> pc=RESET_PC, state INIT, fetch_cnt=0.
